// File: rtl/serializador_rom8x16.sv
// -----------------------------------------------------------------------------
// serializador_rom8x16
// Pixel serializer on the read side of the 8x16 character ROM. The pixel
// timing {pix_tick, video_on, pix_x} is delayed by ROM_LAT clocks so that it
// lines up with the ROM row word. On each delayed pixel tick the row word is
// shifted out MSB first as a 12-bit RGB colour.
//
// Ports:
//   reloj      in   1  system clock
//   resetM     in   1  synchronous, active-high reset
//   pix_tick   in   1  one-clock pixel enable
//   pix_x      in   3  pixel column within the character
//   video_on   in   1  active-display flag for the current pixel
//   rom_data   in   8  ROM row word, bit 7 is the leftmost pixel
//   rgb        out 12  pixel colour, held between updates
//   pix_valid  out  1  one-clock pulse on each clock where rgb updates
//   desync     out  1  one-clock pulse when the shifter is realigned
//                      mid-character
// -----------------------------------------------------------------------------
module serializador_rom8x16 #(
   parameter int          ROM_LAT  = 2,
   parameter logic [11:0] COLOR_FG = 12'hFFF,
   parameter logic [11:0] COLOR_BG = 12'h000
) (
   input  logic        reloj,
   input  logic        resetM,
   input  logic        pix_tick,
   input  logic [2:0]  pix_x,
   input  logic        video_on,
   input  logic [7:0]  rom_data,
   output logic [11:0] rgb,
   output logic        pix_valid,
   output logic        desync
);

   // Each delay stage holds {tick, von, x[2:0]}.
   logic [4:0]  dl_q [ROM_LAT];

   logic        tick_d_s;
   logic        von_d_s;
   logic [2:0]  x_d_s;

   logic [7:0]  sr_q,    sr_d;
   logic [2:0]  cnt_q,   cnt_d;
   logic        armed_q, armed_d;
   logic [11:0] rgb_q,   rgb_d;
   logic        pv_q,    pv_d;
   logic        ds_q,    ds_d;

   logic        out_bit_s;
   logic [3:0]  shamt_s;

   assign tick_d_s = dl_q[ROM_LAT-1][4];
   assign von_d_s  = dl_q[ROM_LAT-1][3];
   assign x_d_s    = dl_q[ROM_LAT-1][2:0];

   // Shift amount for a realignment: x_d+1 can reach 8, which clears the word.
   assign shamt_s  = {1'b0, x_d_s} + 4'd1;

   // Delay line aligning pixel timing with the ROM output; reset drops
   // any ticks still in flight.
   always_ff @(posedge reloj) begin
      if (resetM) begin
         for (int i = 0; i < ROM_LAT; i++) begin
            dl_q[i] <= 5'd0;
         end
      end else begin
         dl_q[0] <= {pix_tick, video_on, pix_x};
         for (int i = 1; i < ROM_LAT; i++) begin
            dl_q[i] <= dl_q[i-1];
         end
      end
   end

   // Next-state decode: hold, blank, load, shift or realign.
   always_comb begin
      sr_d      = sr_q;
      cnt_d     = cnt_q;
      armed_d   = armed_q;
      rgb_d     = rgb_q;
      pv_d      = 1'b0;
      ds_d      = 1'b0;
      out_bit_s = 1'b0;
      if (tick_d_s) begin
         pv_d = 1'b1;
         if (!von_d_s) begin
            // Blanking is always black, independent of the background colour.
            rgb_d   = 12'h000;
            cnt_d   = 3'd0;
            armed_d = 1'b0;
         end else begin
            if (x_d_s == 3'd0) begin
               // Start of character: load has priority over any stale state.
               out_bit_s = rom_data[7];
               sr_d      = rom_data << 1;
               cnt_d     = 3'd1;
               armed_d   = 1'b1;
            end else if (armed_q && (cnt_q == x_d_s)) begin
               out_bit_s = sr_q[7];
               sr_d      = sr_q << 1;
               cnt_d     = cnt_q + 3'd1;
            end else begin
               // Shifter lost track of the column: pick the bit straight from
               // the ROM word and re-seed the shifter past it. Only flagged
               // when the shifter was believed to be in step.
               out_bit_s = rom_data[3'd7 - x_d_s];
               sr_d      = rom_data << shamt_s;
               cnt_d     = x_d_s + 3'd1;
               armed_d   = 1'b1;
               ds_d      = armed_q;
            end
            rgb_d = out_bit_s ? COLOR_FG : COLOR_BG;
         end
      end else begin
         pv_d = 1'b0;
      end
   end

   // Shifter state and registered outputs.
   always_ff @(posedge reloj) begin
      if (resetM) begin
         sr_q    <= 8'd0;
         cnt_q   <= 3'd0;
         armed_q <= 1'b0;
         rgb_q   <= 12'h000;
         pv_q    <= 1'b0;
         ds_q    <= 1'b0;
      end else begin
         sr_q    <= sr_d;
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
         rgb_q   <= rgb_d;
         pv_q    <= pv_d;
         ds_q    <= ds_d;
      end
   end

   assign rgb       = rgb_q;
   assign pix_valid = pv_q;
   assign desync    = ds_q;

endmodule
